// File: rtl/mmm_pkg.sv
// Shared types and sizing helpers for the bit-serial Montgomery multiplier.
// The final subtraction stage is built only when MMM_FINAL_SUB_EN is defined.
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } mmm_state_t;

  localparam int MMM_WIDTH = 8;
  // The accumulator carries one extra bit because it holds values below 2M.
  localparam int MMM_ACC_W = MMM_WIDTH + 1;

  // Width of the iteration counter, which must be able to reach WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mmm_serial_datapath_step.sv
// One combinational radix-2 Montgomery iteration:
// acc_next = (acc + a_bit*b + q*m) / 2, where q makes the sum even.
module mmm_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_next
);

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] t2;

  // NOTE: blocking assignments with a default-first value keep this block
  // purely combinational; every path assigns every output, so no latch.
  always_comb begin
    t        = {1'b0, acc} + {2'b00, (a_bit ? b : '0)};
    t2       = t + (t[0] ? {2'b00, m} : '0);
    acc_next = t2[WIDTH+1:1];
  end

endmodule

// File: rtl/mmm_serial_datapath.sv
// Bit-serial Montgomery multiplier: p = a*b*2^-WIDTH mod m over WIDTH steps.
// Define MMM_FINAL_SUB_EN to add the SUB stage that guarantees p < m.
module mmm_serial_datapath
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             rst_mmm,
  input  logic             ld_a,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int ACC_W = WIDTH + 1;
  localparam int CNT_W = cnt_width(WIDTH);

  mmm_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  mmm_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .a_bit    (a_sh[0]),
    .b        (b_r),
    .m        (m_r),
    .acc_next (acc_next)
  );

  // NOTE: all state, including the operand snapshots, sits on the async
  // reset so that an aborted operation can never leak stale operands.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      a_sh  <= '0;
      b_r   <= '0;
      m_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
      done  <= 1'b0;
    end else if (ena) begin
      if (!rst_mmm) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        p     <= '0;
        done  <= 1'b0;
      end else if (ld_a) begin
        // A load restarts from any state, aborting work in flight.
        a_sh  <= a;
        b_r   <= b;
        m_r   <= m;
        acc   <= '0;
        cnt   <= '0;
        done  <= 1'b0;
        state <= ITER;
      end else begin
        case (state)
          ITER: begin
            acc  <= acc_next;
            a_sh <= a_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (last_step) begin
`ifdef MMM_FINAL_SUB_EN
              state <= SUB;
`else
              // Without the final subtraction the result lies in [0, 2m).
              p     <= acc_next[WIDTH-1:0];
              done  <= 1'b1;
              state <= DONE;
`endif
            end
          end
`ifdef MMM_FINAL_SUB_EN
          SUB: begin
            p     <= (acc >= {1'b0, m_r}) ? WIDTH'(acc - {1'b0, m_r})
                                          : acc[WIDTH-1:0];
            done  <= 1'b1;
            state <= DONE;
          end
`endif
          IDLE, DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmm_serial_datapath.sv
// Directed bench for mmm_serial_datapath (WIDTH=8, m=13); adapts its expected
// latency and result exactness to whether MMM_FINAL_SUB_EN is defined.
module tb_mmm_serial_datapath;

  localparam int WIDTH = 8;
`ifdef MMM_FINAL_SUB_EN
  localparam int LAT = WIDTH + 1;
`else
  localparam int LAT = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rstb;
  logic             ena;
  logic             rst_mmm;
  logic             ld_a;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] p;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [WIDTH-1:0] p_hold;

  mmm_serial_datapath #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .rst_mmm (rst_mmm),
    .ld_a    (ld_a),
    .a       (a),
    .b       (b),
    .m       (m),
    .p       (p),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse ld_a for exactly one sampling edge.
  task automatic start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] mv);
    @(negedge clk);
    a    = av;
    b    = bv;
    m    = mv;
    ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
  endtask

  // Count edges after the load edge until done; ena is low for edges
  // gap_start+1 .. gap_start+gap_len. Returns -1 on timeout.
  task automatic wait_done(input int gap_start, input int gap_len, output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      ena = !(k > gap_start && k <= gap_start + gap_len);
      @(negedge clk);
      if (done) begin
        n = k;
        break;
      end
    end
    ena = 1'b1;
  endtask

  // Exact residue with the final subtraction, otherwise congruent and < 2m.
  task automatic check_p(input string tag, input logic [WIDTH-1:0] exp);
`ifdef MMM_FINAL_SUB_EN
    check(tag, 32'(p), 32'(exp));
`else
    check(tag, 32'(p % 8'd13), 32'(exp));
    check({tag, "_range"}, 32'(p < 8'd26), 32'd1);
`endif
  endtask

  initial begin
    rstb    = 1'b0;
    ena     = 1'b1;
    rst_mmm = 1'b1;
    ld_a    = 1'b0;
    a       = '0;
    b       = '0;
    m       = '0;
    #12;
    check("reset_p", 32'(p), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rstb = 1'b1;

    // 5*7*2^-8 mod 13 = 35*3 mod 13 = 1
    start(8'd5, 8'd7, 8'd13);
    wait_done(0, 0, cyc);
    check("lat_5x7", 32'(cyc), 32'(LAT));
    check_p("p_5x7", 8'd1);
    p_hold = p;
    repeat (3) @(negedge clk);
    check("hold_done", 32'(done), 32'd1);
    check("hold_p", 32'(p), 32'(p_hold));

    // 12*12*2^-8 mod 13 = 1*3 = 3
    start(8'd12, 8'd12, 8'd13);
    wait_done(0, 0, cyc);
    check("lat_12x12", 32'(cyc), 32'(LAT));
    check_p("p_12x12", 8'd3);

    // Zero multiplier gives an exact zero in either build.
    start(8'd0, 8'd9, 8'd13);
    wait_done(0, 0, cyc);
    check("lat_0x9", 32'(cyc), 32'(LAT));
    check("p_0x9", 32'(p), 32'd0);

    // Three ena-low cycles mid-ITER stretch latency by exactly three.
    start(8'd5, 8'd7, 8'd13);
    wait_done(3, 3, cyc);
    check("lat_ena_gap", 32'(cyc), 32'(LAT + 3));
    check_p("p_ena_gap", 8'd1);

    // Second load at edge N+4 aborts the first operation.
    start(8'd5, 8'd7, 8'd13);
    repeat (2) @(negedge clk);
    start(8'd12, 8'd12, 8'd13);
    wait_done(0, 0, cyc);
    check("lat_restart", 32'(cyc), 32'(LAT));
    check_p("p_restart", 8'd3);

    // Synchronous clear from DONE.
    rst_mmm = 1'b0;
    @(negedge clk);
    rst_mmm = 1'b1;
    check("clr_p", 32'(p), 32'd0);
    check("clr_done", 32'(done), 32'd0);

    // Async reset mid-ITER while p still holds a nonzero result.
    start(8'd12, 8'd12, 8'd13);
    wait_done(0, 0, cyc);
    check("lat_pre_rst", 32'(cyc), 32'(LAT));
    start(8'd5, 8'd7, 8'd13);
    repeat (2) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check("arst_p", 32'(p), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    start(8'd5, 8'd7, 8'd13);
    wait_done(0, 0, cyc);
    check("lat_post_rst", 32'(cyc), 32'(LAT));
    check_p("p_post_rst", 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
